id_ex_pipe: RTL
===============

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter ALUOP_W, default 4, ALU operation code width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have inputs id_valid 1, id_pc XLEN, id_imm XLEN, id_rs1 5, id_rs2 5, id_rd 5, id_alu_op ALUOP_W, id_use_rs1 1, id_use_rs2 1, id_mem_read 1, id_mem_write 1, id_reg_write 1: decoded ID instruction.
REQ-006 SHALL have inputs busA XLEN, busB XLEN: register-file read data for id_rs1/id_rs2.
REQ-007 SHALL have inputs wb_reg_write 1, wb_rd 5, wb_data XLEN: writeback port, same signals driving the register file write.
REQ-008 SHALL have input flush 1: squash the instruction entering EX (branch redirect).
REQ-009 SHALL have outputs ex_valid 1, ex_pc XLEN, ex_imm XLEN, ex_op_a XLEN, ex_op_b XLEN, ex_rs1 5, ex_rs2 5, ex_rd 5, ex_alu_op ALUOP_W, ex_mem_read 1, ex_mem_write 1, ex_reg_write 1: registered EX-stage bundle.
REQ-010 SHALL have output stall 1: hold PC and IF/ID register this cycle.

Function
REQ-011 Operand A SHALL be: 0 if id_rs1==0; else wb_data if WB bypass hit (REQ-024); else busA. Operand B identical with id_rs2/busB.
REQ-012 Load-use hazard SHALL be: id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-013 stall SHALL be combinational: hazard & ~flush; 0 whenever reset is high.
REQ-014 Register update priority SHALL be reset > flush > hazard > capture.
REQ-015 Flush: ex_valid, ex_mem_read, ex_mem_write, ex_reg_write SHALL load 0; data fields don't care.
REQ-016 Hazard (no flush): bubble inserted -- control bits and ex_valid SHALL load 0; ID instruction is retained upstream and captured the following cycle.
REQ-017 Capture: all fields SHALL load from ID; ex_valid<=id_valid; ex_mem_read/ex_mem_write/ex_reg_write SHALL be ANDed with id_valid.
REQ-018 Latency ID->EX SHALL be exactly one cycle; no bubble unless hazard or flush.
REQ-019 Flush and hazard in same cycle: flush wins, stall=0.
REQ-020 ex_reg_write SHALL be forced 0 when id_rd==0 at capture.
REQ-021 Back-to-back loads into same rd SHALL stall each dependent consumer exactly one cycle; no double stall.

Reset
REQ-022 While reset high at a clock edge, every registered output SHALL load 0 (ex_valid=0, all buses 0).
REQ-023 Reset asserted mid-stall SHALL clear the bubble and stall SHALL drop combinationally with ex_valid.

Configuration
REQ-024 Macro WB_BYPASS_EN defined: bypass hit = wb_reg_write & wb_rd!=0 & wb_rd==source index, giving write-before-read on same-cycle register-file write.
REQ-025 WB_BYPASS_EN undefined: no bypass; operands SHALL be busA/busB (x0 still forced 0); wb_* inputs unused; writeback-to-ID dependencies SHALL be resolved by the instruction scheduler.

Structure
REQ-026 XLEN default, register-index width (5), ALU op encodings and x0 index SHALL live in shared package RISCV.sv.
REQ-027 Load-use detection SHALL be sub-module id_hazard_unit (combinational, outputs hazard); the rest is the pipeline register in id_ex_pipe.

Verification
REQ-028 Reset 2 cycles with id_valid=1 -> all outputs 0, stall=0; first capture on the edge after reset deasserts.
REQ-029 ID add rs1=5,rs2=6, busA=0x10, busB=0x20 -> next cycle ex_op_a=0x10, ex_op_b=0x20, ex_valid=1.
REQ-030 EX lw rd=7; ID add rs1=7 -> stall=1 one cycle, bubble (ex_valid=0), add captured next cycle with stall=0.
REQ-031 Same as REQ-030 with flush=1 -> stall=0, ex_valid=0 next cycle.
REQ-032 WB_BYPASS_EN: wb_reg_write=1, wb_rd=9, wb_data=0xDEADBEEF, id_rs1=9, busA=0x1 -> ex_op_a=0xDEADBEEF; without macro -> 0x1.
REQ-033 id_rs2=0, busB=0x55, wb_rd=0 write of 0x77 -> ex_op_b=0; id_rd=0 -> ex_reg_write=0.

Source files
------------

// File: rtl/RISCV.sv
// Shared RISC-V core constants: datapath width, register index width,
// x0 index and ALU operation encodings.
package RISCV;

  localparam int XLEN_DEF = 32;
  localparam int REG_W    = 5;
  localparam int ALUOP_WD = 4;

  localparam logic [REG_W-1:0] X0 = '0;

  typedef enum logic [ALUOP_WD-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/id_hazard_unit.sv
// Load-use hazard detection between the ID instruction and a load in EX.
module id_hazard_unit
  import RISCV::*;
(
  input  logic             id_valid,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hazard
);

  logic hit1;
  logic hit2;

  assign hit1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit2 = id_use_rs2 && (id_rs2 == ex_rd);

  assign hazard = id_valid && ex_valid && ex_mem_read
                && (ex_rd != X0) && (hit1 || hit2);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with operand select and load-use stall.
// Optional WB_BYPASS_EN forwards the writeback value into the operands.
module id_ex_pipe
  import RISCV::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ALUOP_W = ALUOP_WD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [REG_W-1:0]   id_rs1,
  input  logic [REG_W-1:0]   id_rs2,
  input  logic [REG_W-1:0]   id_rd,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_write,
  input  logic [XLEN-1:0]    busA,
  input  logic [XLEN-1:0]    busB,
  input  logic               wb_reg_write,
  input  logic [REG_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_imm,
  output logic [XLEN-1:0]    ex_op_a,
  output logic [XLEN-1:0]    ex_op_b,
  output logic [REG_W-1:0]   ex_rs1,
  output logic [REG_W-1:0]   ex_rs2,
  output logic [REG_W-1:0]   ex_rd,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               stall
);

  logic            hazard;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  id_hazard_unit u_hazard (
    .id_valid    (id_valid),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  assign stall = hazard && !flush && !reset;

`ifdef WB_BYPASS_EN
  logic byp_a;
  logic byp_b;

  assign byp_a = wb_reg_write && (wb_rd != X0) && (wb_rd == id_rs1);
  assign byp_b = wb_reg_write && (wb_rd != X0) && (wb_rd == id_rs2);

  always_comb begin
    op_a = busA;
    op_b = busB;
    if (id_rs1 == X0) op_a = '0;
    else if (byp_a)   op_a = wb_data;
    if (id_rs2 == X0) op_b = '0;
    else if (byp_b)   op_b = wb_data;
  end
`else
  // Writeback dependencies are left to the scheduler in this build.
  logic wb_unused;
  assign wb_unused = ^{wb_reg_write, wb_rd, wb_data};

  always_comb begin
    op_a = busA;
    op_b = busB;
    if (id_rs1 == X0) op_a = '0;
    if (id_rs2 == X0) op_b = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_alu_op    <= '0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
    end else if (flush || hazard) begin
      // Squash or bubble: only the control bits matter.
      ex_valid     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_imm       <= id_imm;
      ex_op_a      <= op_a;
      ex_op_b      <= op_b;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_alu_op    <= id_alu_op;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_mem_write <= id_valid && id_mem_write;
      ex_reg_write <= id_valid && id_reg_write && (id_rd != X0);
    end
  end

endmodule
